// File: rtl/imul_seq.sv
// imul_seq: sequential shift-and-add integer multiplier.
// Signed operands are reduced to magnitudes when the request is accepted, so
// the core loop only ever multiplies unsigned values. The product sign is
// applied once, on the final step. The core handles one multiplier bit per
// cycle, so an NB-bit operation takes NB cycles in RUN followed by one DONE cycle.
module imul_seq #(
   parameter int NB = 16
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              iStart,
   input  logic              iSigned,
   input  logic [NB-1:0]     iA,
   input  logic [NB-1:0]     iB,
   output logic              oBusy,
   output logic              oDone,
   output logic [2*NB-1:0]   oResult
);

   localparam int CW = $clog2(NB);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_next;

   logic [2*NB-1:0]   r_mcand;   // multiplicand magnitude, shifted left each step
   logic [NB-1:0]     r_mplr;    // multiplier magnitude, shifted right each step
   logic [2*NB-1:0]   r_acc;
   logic [CW-1:0]     r_cnt;
   logic              r_neg;
   logic [2*NB-1:0]   r_result;

   logic              w_accept;
   logic              w_last;
   logic              w_a_neg;
   logic              w_b_neg;
   logic [NB-1:0]     w_a_mag;
   logic [NB-1:0]     w_b_mag;
   logic [2*NB-1:0]   w_addend;
   logic [2*NB-1:0]   w_acc_sum;

   // A request is taken in IDLE or DONE; a start seen during RUN is dropped.
   assign w_accept  = iStart && (r_state != S_RUN);
   assign w_last    = (r_cnt == CW'(NB-1));

   // The most negative value maps to 2^(NB-1), which still fits as an unsigned NB-bit magnitude.
   assign w_a_neg   = iSigned & iA[NB-1];
   assign w_b_neg   = iSigned & iB[NB-1];
   assign w_a_mag   = w_a_neg ? (-iA) : iA;
   assign w_b_mag   = w_b_neg ? (-iB) : iB;

   assign w_addend  = r_mplr[0] ? r_mcand : '0;
   assign w_acc_sum = r_acc + w_addend;

   assign oResult   = r_result;

   // State register.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   // Next-state and status outputs.
   always_comb begin
      w_next = r_state;
      oBusy  = 1'b0;
      oDone  = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) w_next = S_RUN;
         end
         S_RUN: begin
            oBusy = 1'b1;
            if (w_last) w_next = S_DONE;
         end
         S_DONE: begin
            oDone  = 1'b1;
            w_next = w_accept ? S_RUN : S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: latch operands on accept, then one shift-and-add per RUN cycle.
   // The result register changes only on the last step, so a following
   // operation leaves the previous product visible until its own completion.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         r_mcand  <= '0;
         r_mplr   <= '0;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= 1'b0;
         r_result <= '0;
      end else if (w_accept) begin
         r_mcand  <= {{NB{1'b0}}, w_a_mag};
         r_mplr   <= w_b_mag;
         r_acc    <= '0;
         r_cnt    <= '0;
         r_neg    <= w_a_neg ^ w_b_neg;
      end else if (r_state == S_RUN) begin
         r_acc    <= w_acc_sum;
         r_mcand  <= r_mcand << 1;
         r_mplr   <= r_mplr >> 1;
         r_cnt    <= r_cnt + CW'(1);
         if (w_last) r_result <= r_neg ? (-w_acc_sum) : w_acc_sum;
      end
   end

endmodule

// File: tb/tb_imul_seq.sv
// Bench for imul_seq: an NB=16 and an NB=4 instance share clock and reset.
// A transaction-level model (remaining-cycle count plus arithmetic product)
// predicts busy/done/result every cycle; directed cases pin literal values.
module tb_imul_seq;

   logic Clock = 1'b0;
   logic Reset = 1'b1;
   always #5 Clock = ~Clock;

   logic        st16 = 0, sg16 = 0;
   logic [15:0] a16 = 0, b16 = 0;
   logic        busy16, done16;
   logic [31:0] res16;

   logic        st4 = 0, sg4 = 0;
   logic [3:0]  a4 = 0, b4 = 0;
   logic        busy4, done4;
   logic [7:0]  res4;

   imul_seq #(.NB(16)) u16 (
      .Clock(Clock), .Reset(Reset), .iStart(st16), .iSigned(sg16),
      .iA(a16), .iB(b16), .oBusy(busy16), .oDone(done16), .oResult(res16));

   imul_seq #(.NB(4)) u4 (
      .Clock(Clock), .Reset(Reset), .iStart(st4), .iSigned(sg4),
      .iA(a4), .iB(b4), .oBusy(busy4), .oDone(done4), .oResult(res4));

   int vectors = 0;
   int miscompares = 0;
   bit chk_en = 0;

   function automatic longint unsigned ref_prod(longint unsigned a, longint unsigned b,
                                                bit s, int nb);
      longint sa, sb, p, mask;
      sa = longint'(a);
      sb = longint'(b);
      if (s && a[nb-1]) sa = sa - (longint'(1) << nb);
      if (s && b[nb-1]) sb = sb - (longint'(1) << nb);
      p    = sa * sb;
      mask = (longint'(1) << (2*nb)) - 1;
      return longint'(p & mask);
   endfunction

   task automatic check(string nm, longint unsigned act, longint unsigned exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: index 0 = NB16 instance, 1 = NB4 instance.
   int              m_rem  [2];
   bit              m_done [2];
   longint unsigned m_res  [2];
   longint unsigned m_pend [2];

   always @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         for (int i = 0; i < 2; i++) begin
            m_rem[i]  <= 0;
            m_done[i] <= 0;
            m_res[i]  <= 0;
            m_pend[i] <= 0;
         end
      end else begin
         for (int i = 0; i < 2; i++) begin
            m_done[i] <= 0;
            if (m_rem[i] > 0) begin
               m_rem[i] <= m_rem[i] - 1;
               if (m_rem[i] == 1) begin
                  m_res[i]  <= m_pend[i];
                  m_done[i] <= 1;
               end
            end else if ((i == 0) ? st16 : st4) begin
               m_rem[i]  <= (i == 0) ? 16 : 4;
               m_pend[i] <= (i == 0) ? ref_prod(a16, b16, sg16, 16)
                                     : ref_prod(a4, b4, sg4, 4);
            end
         end
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge Clock) begin
      if (chk_en) begin
         check("busy16", busy16, m_rem[0] > 0);
         check("done16", done16, m_done[0]);
         check("res16",  res16,  m_res[0]);
         check("busy4",  busy4,  m_rem[1] > 0);
         check("done4",  done4,  m_done[1]);
         check("res4",   res4,   m_res[1]);
      end
   end

   // Called just after a negedge; returns at the negedge following the accept edge.
   task automatic start_op(int inst, longint unsigned a, longint unsigned b, bit s);
      if (inst == 0) begin
         a16 = a[15:0]; b16 = b[15:0]; sg16 = s; st16 = 1;
      end else begin
         a4 = a[3:0]; b4 = b[3:0]; sg4 = s; st4 = 1;
      end
      @(negedge Clock);
      st16 = 0;
      st4  = 0;
   endtask

   task automatic wait_done(int inst, output int lat);
      lat = 0;
      while (!((inst == 0) ? done16 : done4) && lat < 60) begin
         @(negedge Clock);
         lat++;
      end
      if (lat >= 60) begin
         vectors++;
         miscompares++;
         $display("FAIL timeout%0d: no done within %0d cycles", inst, lat);
      end
   endtask

   task automatic run_op16(longint unsigned a, longint unsigned b, bit s,
                           longint unsigned exp);
      int lat;
      start_op(0, a, b, s);
      wait_done(0, lat);
      check("lat16", lat, 16);
      check("res16_lit", res16, exp);
   endtask

   initial begin
      int n, lat, prev, cyc, ndone;
      #1 Reset = 0;
      chk_en = 1;
      #2;
      check("rst_busy16", busy16, 0);
      check("rst_done16", done16, 0);
      check("rst_res16",  res16,  0);

      // Start already requested when reset is released: first edge accepts it.
      @(negedge Clock);
      a4 = 3; b4 = 2; sg4 = 0; st4 = 1;
      @(negedge Clock);
      Reset = 1;
      @(negedge Clock);
      st4 = 0;
      check("first_edge_busy4", busy4, 1);
      wait_done(1, lat);
      check("lat4_first", lat, 4);
      check("res4_first", res4, 6);
      @(negedge Clock);

      // 0xFFFF * 0xFFFF unsigned, busy for exactly 16 cycles.
      start_op(0, 16'hFFFF, 16'hFFFF, 0);
      n = 0;
      while (busy16 && n < 60) begin
         n++;
         @(negedge Clock);
      end
      check("busy_cycles", n, 16);
      check("done_after_busy", done16, 1);
      check("ffff_sq", res16, 32'hFFFE0001);
      @(negedge Clock);
      check("done_one_cycle", done16, 0);

      run_op16(16'h8000, 16'h8000, 1, 32'h40000000);
      run_op16(16'hFFFD, 16'h0007, 1, 32'hFFFFFFEB);
      run_op16(16'h0000, 16'h1234, 0, 32'h0);
      run_op16(16'hFFFF, 16'hFFFF, 1, 32'h1);

      // Back-to-back: start in the done cycle, old result held until new done.
      run_op16(16'h1234, 16'h0010, 0, 32'h12340);
      a16 = 3; b16 = 5; sg16 = 0; st16 = 1;
      @(negedge Clock);
      st16 = 0;
      check("b2b_busy", busy16, 1);
      check("b2b_hold", res16, 32'h12340);
      wait_done(0, lat);
      check("b2b_lat", lat, 16);
      check("b2b_res", res16, 15);
      @(negedge Clock);

      // Start held high with operands changing every cycle.
      st16 = 1; sg16 = 0;
      prev = -1; cyc = 0; ndone = 0;
      repeat (60) begin
         a16 = 16'($urandom); b16 = 16'($urandom);
         @(negedge Clock);
         cyc++;
         if (done16) begin
            if (prev >= 0) check("b2b_period", cyc - prev, 17);
            prev = cyc;
            ndone++;
         end
      end
      check("b2b_count", ndone, 3);
      st16 = 0;
      repeat (20) @(negedge Clock);

      // Random free-running traffic on both instances.
      repeat (600) begin
         st16 = ($urandom_range(0, 3) == 0); sg16 = 1'($urandom);
         a16 = 16'($urandom); b16 = 16'($urandom);
         st4  = ($urandom_range(0, 2) == 0); sg4 = 1'($urandom);
         a4 = 4'($urandom); b4 = 4'($urandom);
         @(negedge Clock);
      end
      st16 = 0; st4 = 0;
      repeat (20) @(negedge Clock);

      // Asynchronous reset mid-operation.
      start_op(0, 16'hABCD, 16'h1234, 0);
      repeat (7) @(negedge Clock);
      #2 Reset = 0;
      #1;
      check("arst_busy", busy16, 0);
      check("arst_done", done16, 0);
      check("arst_res",  res16,  0);
      @(negedge Clock);
      Reset = 1;
      ndone = 0;
      repeat (25) begin
         @(negedge Clock);
         if (done16) ndone++;
      end
      check("arst_no_done", ndone, 0);

      // NB=4 exhaustive sweep, both modes.
      for (int s = 0; s < 2; s++)
         for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++) begin
               start_op(1, a, b, s[0]);
               wait_done(1, lat);
               check("sweep_lat", lat, 4);
               check("sweep_res", res4, ref_prod(a, b, s[0], 4));
            end
      @(negedge Clock);
      check("sweep_min_sq", ref_prod(8, 8, 1, 4), 8'h40);

      chk_en = 0;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
